uart_tx_arbiter: RTL and testbench

- Shares the single transmit channel of the UART controller between NUM_REQ independent byte producers, e.g. CPU port, debug monitor and DMA.
- Arbitrates round-robin and latches the winning byte.
- Drives the controller's tx_data_req/tx_data handshake, waits for tx_data_ack, then returns a one-cycle acknowledge to the winning requester.
- Sits between the device-bus side and the UART controller instance.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_arbiter_if.sv | 23 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 100 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side arbiter.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-controller handshake bundle for the TX arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]             req;
    logic [UART_DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ack;
    logic                           tx_data_req;
    logic [UART_DATA_W-1:0]         tx_data;
    logic                           tx_data_ack;

    modport master (
        input  req, req_data, tx_data_ack,
        output req_ack, tx_data_req, tx_data
    );

    modport slave (
        output req, req_data, tx_data_ack,
        input  req_ack, tx_data_req, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after 'last'.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);
    // Scan from farthest to nearest so the nearest hit is written last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(last) + k) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the UART TX byte handshake among NUM_REQ producers.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    uart_tx_arbiter_if.master bus,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);
    state_e                 state_q, state_d;
    logic [UART_DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   txreq_q, txreq_d;
    logic                   busy_q, busy_d;
    logic                   found;
    logic [IDX_W-1:0]       win;

    rr_picker #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .last  (last_q),
        .found (found),
        .winner(win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            ack_q   <= '0;
            txreq_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            txreq_q <= txreq_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        ack_d   = ack_q;
        txreq_d = txreq_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                ack_d   = '0;
                txreq_d = 1'b0;
                busy_d  = 1'b0;
                if (en && found) begin
                    data_d  = bus.req_data[UART_DATA_W*int'(win) +: UART_DATA_W];
                    grant_d = win;
                    txreq_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.tx_data_ack) begin
                    txreq_d = 1'b0;
                    ack_d   = NUM_REQ'(1) << grant_q;
                    last_d  = grant_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ack_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.tx_data_req = txreq_q;
    assign bus.tx_data     = data_q;
    assign bus.req_ack     = ack_q;
    assign busy            = busy_q;
    assign grant_idx       = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a transaction-level RR model.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       busy;
    logic [1:0] grant_idx;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(N),
        .IDX_W  (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .bus      (bus),
        .busy     (busy),
        .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] rq[N][$];
    exp_t       sb[$];
    int         m_last = N - 1;
    logic [N-1:0] drop = '0;
    int         mode = 0;
    logic       man_ack = 1'b0;
    logic       rand_en = 1'b0;
    logic       ack_edge = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++)
            if (m[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Predict the full grant order for everything currently queued.
    task automatic plan();
        int pos[N];
        int left[N];
        logic [N-1:0] m;
        int w;
        for (int i = 0; i < N; i++) begin
            pos[i]  = 0;
            left[i] = rq[i].size();
        end
        while (1) begin
            for (int i = 0; i < N; i++) m[i] = left[i] > 0;
            if (m == '0) break;
            w = rr_pick(m, m_last);
            sb.push_back('{w, rq[w][pos[w]]});
            pos[w]++;
            left[w]--;
            m_last = w;
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input int budget);
        int c = 0;
        while (!(all_empty() && !busy && sb.size() == 0) && c < budget) begin
            if (rand_en) en = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d left expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        sb.delete();
        m_last = N - 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Requesters: hold until acked, then present the next byte.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst && bus.req_ack[i] && rq[i].size() > 0)
                void'(rq[i].pop_front());
            bus.req[i] = (rq[i].size() > 0) && !drop[i];
            bus.req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
        end
    end

    // UART controller model.
    int rcnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            bus.tx_data_ack = 1'b0;
            rcnt = 0;
        end else if (mode == 3) begin
            bus.tx_data_ack = man_ack;
        end else if (bus.tx_data_ack) begin
            bus.tx_data_ack = 1'b0;
        end else if (bus.tx_data_req) begin
            rcnt++;
            if (mode == 0) bus.tx_data_ack = ($urandom_range(0, 2) == 0);
            else if (mode == 1) bus.tx_data_ack = (rcnt >= 5);
            else bus.tx_data_ack = 1'b0;
        end else begin
            rcnt = 0;
            bus.tx_data_ack = (mode == 0) && ($urandom_range(0, 5) == 0);
        end
    end

    always @(posedge clk)
        ack_edge = !rst && bus.tx_data_req && bus.tx_data_ack;

    // Monitor: compare DUT behaviour against the scoreboard.
    logic       prev_tx = 1'b0;
    logic       post_ack = 1'b0;
    int         cur_idx = 0;
    logic [7:0] cur_data = 8'h00;
    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0] ea;
        if (rst) begin
            prev_tx  = 1'b0;
            post_ack = 1'b0;
        end else begin
            ea = ack_edge ? (N'(1) << cur_idx) : '0;
            if (ack_edge || bus.req_ack != '0)
                chk("req_ack", 32'(bus.req_ack), 32'(ea));
            if (bus.req_ack != '0)
                chk("ack_vs_txreq", 32'(bus.tx_data_req), 32'(0));
            if (post_ack) chk("busy_after_ack", 32'(busy), 32'(0));
            if (bus.tx_data_req && !prev_tx) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_grant: got idx %0d expected none",
                             grant_idx);
                end else begin
                    e = sb.pop_front();
                    cur_idx  = e.idx;
                    cur_data = e.data;
                    chk("grant_idx", 32'(grant_idx), 32'(e.idx));
                    chk("tx_data", 32'(bus.tx_data), 32'(e.data));
                    chk("busy_send", 32'(busy), 32'(1));
                end
            end else if (bus.tx_data_req) begin
                chk("tx_data_hold", 32'(bus.tx_data), 32'(cur_data));
            end
            post_ack = ack_edge;
            prev_tx  = bus.tx_data_req;
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txreq", 32'(bus.tx_data_req), 32'(0));
        chk("rst_txdata", 32'(bus.tx_data), 32'(0));
        chk("rst_reqack", 32'(bus.req_ack), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_grant", 32'(grant_idx), 32'(0));
        rst = 1'b0;
        en  = 1'b1;

        // Single request, UART answers after a fixed delay.
        mode = 1;
        rq[0].push_back(8'h41);
        plan();
        @(posedge clk);
        #1;
        chk("single_latency", 32'(bus.tx_data_req), 32'(1));
        chk("single_data", 32'(bus.tx_data), 32'(8'h41));
        drain(200);

        // All four requesting from reset: 0,1,2,3,0.
        do_reset();
        mode = 0;
        rq[0].push_back(8'hA0);
        rq[0].push_back(8'hA0);
        rq[1].push_back(8'hA1);
        rq[2].push_back(8'hA2);
        rq[3].push_back(8'hA3);
        plan();
        drain(400);

        // Fairness wrap after a grant to 2.
        rq[2].push_back(8'hC2);
        plan();
        drain(200);
        rq[0].push_back(8'hB0);
        rq[1].push_back(8'hB1);
        rq[3].push_back(8'hB3);
        plan();
        drain(400);

        // Enable gating and dropping enable mid-transfer.
        en = 1'b0;
        rq[2].push_back(8'h77);
        plan();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("en0_no_grant", 32'(bus.tx_data_req), 32'(0));
        end
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("en1_grant", 32'(bus.tx_data_req), 32'(1));
        chk("en1_idx", 32'(grant_idx), 32'(2));
        en = 1'b0;
        drain(200);
        en = 1'b1;

        // Reset while a byte is in flight.
        mode = 2;
        rq[2].push_back(8'h55);
        plan();
        @(posedge clk);
        #1;
        chk("midsend_txdata", 32'(bus.tx_data), 32'(8'h55));
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        chk("post_rst_txreq", 32'(bus.tx_data_req), 32'(0));
        chk("post_rst_busy", 32'(busy), 32'(0));
        chk("post_rst_ack", 32'(bus.req_ack), 32'(0));
        chk("post_rst_grant", 32'(grant_idx), 32'(0));
        mode = 0;
        rq[2].push_back(8'h66);
        rq[0].push_back(8'h12);
        plan();
        drain(300);

        // Spurious ack in IDLE, then requester drops req during SEND.
        mode = 3;
        man_ack = 1'b1;
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("spur_txreq", 32'(bus.tx_data_req), 32'(0));
        chk("spur_busy", 32'(busy), 32'(0));
        rq[1].push_back(8'h5A);
        plan();
        repeat (2) @(posedge clk);
        #1;
        chk("drop_send", 32'(bus.tx_data_req), 32'(1));
        drop[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        man_ack = 1'b1;
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        drain(100);
        drop[1] = 1'b0;

        // Randomized rounds with random enable and spurious acks.
        mode = 0;
        rand_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                int cnt;
                cnt = $urandom_range(0, 3);
                for (int j = 0; j < cnt; j++)
                    rq[i].push_back(8'($urandom));
            end
            plan();
            drain(1000);
        end
        rand_en = 1'b0;
        en = 1'b1;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
